reg_bank_arbiter: RTL
=====================

Name: reg_bank_arbiter

Overview:
Shared register bank of DEPTH words × WIDTH bits, each word built from plain D flip-flops. The bank is time-shared between N_REQ requesters through a round-robin arbiter and a 3-state sequencer (IDLE, GRANT, ACK). Each transaction is a single read or write with a req/gnt/ack handshake. The whole bank is also exposed read-only for LEDs and debug.

Parameters:
N_REQ, 4, number of requesters (2..8).
WIDTH, 8, data word width in bits.
ADDR_W, 2, address width; DEPTH = 2**ADDR_W words.

Ports:
clk  input  1  system clock; all flops update on its rising edge.
rst_n  input  1  asynchronous reset, active low.
req  input  N_REQ  per-requester transaction request, level.
we  input  N_REQ  per-requester direction: 1 = write, 0 = read.
addr  input  N_REQ*ADDR_W  per-requester word address; requester i uses slice [i*ADDR_W +: ADDR_W].
wdata  input  N_REQ*WIDTH  per-requester write data; requester i uses slice [i*WIDTH +: WIDTH].
gnt  output  N_REQ  one-hot grant, registered.
ack  output  N_REQ  one-hot single-cycle completion pulse, registered.
rdata  output  WIDTH  read data of the last completed read.
busy  output  1  high whenever the state is not IDLE.
q_all  output  DEPTH*WIDTH  live bank contents; word k is at [k*WIDTH +: WIDTH].

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately):
  - state=IDLE; gnt=0, ack=0, busy=0, rdata=0.
  - All bank words = 0; q_all=0.
  - Round-robin pointer last = N_REQ-1, so requester 0 has top priority first.
- IDLE:
  - If req != 0, choose winner w = first i with req[i]=1, scanning last+1, last+2, … modulo N_REQ.
  - Latch w; go to GRANT. With no requests, stay in IDLE.
- GRANT (exactly 1 cycle):
  - gnt[w]=1, all other gnt bits 0, busy=1.
  - At the exiting edge, sample we[w], addr slice w and wdata slice w.
  - Write: bank[addr] <= wdata; rdata unchanged.
  - Read: rdata <= bank[addr].
  - Go to ACK.
- ACK (exactly 1 cycle):
  - ack[w]=1, gnt=0, busy=1; rdata is valid from this cycle on.
  - At the exiting edge, last <= w; go to IDLE.
- Latency: req seen in IDLE at edge n gives gnt during cycle n+1 and ack during cycle n+2. Written data appears on q_all in cycle n+2.
- Throughput: at most one transaction every 3 cycles.
- rdata holds its value until the next read completes.
- A requester must drop req in the cycle after ack. If it keeps req high, it re-enters arbitration behind the others because last has advanced.
- req dropped during GRANT: the transaction still completes and ack is still issued. There is no abort.
- Changes to req, we, addr or wdata of non-winners, and of the winner outside GRANT, have no effect.
- Only one transaction is in flight; simultaneous requests are serialized purely by round-robin order.
- Reset asserted mid-transaction: the transaction is discarded. gnt and ack drop asynchronously, and the bank is cleared, including any partially completed write.
- gnt and ack are never both non-zero in the same cycle. Each is either 0 or one-hot.
- The bank is written only in GRANT. q_all is never affected by reads.

Test Plan:
1. Reset: drive random inputs, then pulse rst_n low mid-cycle -> outputs go to 0 immediately with no clock edge needed; q_all=0; busy=0.
2. Single write: req[0]=1, we[0]=1, addr0=2, wdata0=8'hA5 -> gnt=4'b0001 at cycle n+1, ack=4'b0001 at cycle n+2; q_all word2=8'hA5, all other words 0.
3. Readback: req[3]=1, we[3]=0, addr3=2 after test 2 -> ack[3] pulse; rdata=8'hA5 from the ack cycle and held afterwards.
4. Fairness: req=4'b1111 held, each requester writing its own index to word i -> grant order 0,1,2,3,0; ack every 3rd cycle; final q_all = {8'h03,8'h02,8'h01,8'h00}.
5. Drop during GRANT: req[1] deasserted in the gnt[1] cycle, we[1]=1, addr1=1, wdata1=8'h3C -> ack[1] still pulses; word1=8'h3C.
6. Reset mid-transaction: rst_n low during GRANT of a write of 8'hFF to word0 -> gnt=0 at once, word0 stays 0; after release, req=4'b0011 -> requester 0 granted first.

Source files
------------

// File: rtl/reg_bank_if.sv
// Bus bundle between the requesters and the shared register bank.
// req is a level request; gnt marks the one cycle in which the winner's we/addr/wdata
// are sampled; ack is a one-cycle completion pulse after which the requester drops req.
interface reg_bank_if #(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*WIDTH-1:0]  wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        ack;
  logic [WIDTH-1:0]        rdata;
  logic                    busy;
  logic [DEPTH*WIDTH-1:0]  q_all;
  logic [1:0]              dbg_state;

  modport master (
    output req, we, addr, wdata,
    input  gnt, ack, rdata, busy, q_all, dbg_state
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, ack, rdata, busy, q_all, dbg_state
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by N_REQ requesters via round-robin arbitration and a
// three-state IDLE/GRANT/ACK sequencer; one transaction in flight at a time.
module reg_bank_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_bank_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  pick;
  logic [WIDTH-1:0]  bank [DEPTH];
  logic [WIDTH-1:0]  rdata_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  ack_q;
  logic              busy_q;
  logic [N_REQ-1:0]  gnt_d;
  logic [N_REQ-1:0]  ack_d;
  logic              busy_d;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_wdata;

  // Scan last+1, last+2, ... wrapping, so the most recent winner goes to the back.
  always_comb begin
    int  j;
    logic found;
    pick  = last;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(last) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && bus.req[j]) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
  end

  always_comb begin
    sel_we    = bus.we[win];
    sel_addr  = bus.addr[int'(win)*ADDR_W +: ADDR_W];
    sel_wdata = bus.wdata[int'(win)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = (|bus.req) ? GRANT : IDLE;
      GRANT:   next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so gnt/ack/busy are flops.
  always_comb begin
    gnt_d  = '0;
    ack_d  = '0;
    busy_d = (next_state != IDLE);
    if (next_state == GRANT) gnt_d[pick] = 1'b1;
    if (next_state == ACK)   ack_d[win]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= '0;
      ack_q  <= '0;
      busy_q <= 1'b0;
      win    <= '0;
      last   <= IDX_W'(N_REQ - 1);
    end else begin
      gnt_q  <= gnt_d;
      ack_q  <= ack_d;
      busy_q <= busy_d;
      if (state == IDLE && (|bus.req)) win <= pick;
      if (state == ACK) last <= win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) bank[k] <= '0;
      rdata_q <= '0;
    end else if (state == GRANT) begin
      if (sel_we) bank[sel_addr] <= sel_wdata;
      else        rdata_q        <= bank[sel_addr];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_q_all
    assign bus.q_all[k*WIDTH +: WIDTH] = bank[k];
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.rdata     = rdata_q;
  assign bus.dbg_state = state;

endmodule
